// File: rtl/conv3x3_filter.sv
// 3x3 convolution over a column stream from line_buffer: fixed 4-cycle latency,
// runtime kernel select latched at the start of each frame, hcount/vcount tags.
module conv3x3_filter #(
  parameter int HRES = 320,
  parameter int VRES = 160
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [23:0] data_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        data_valid_in,
  input  logic [2:0]  kernel_sel_in,
  output logic [7:0]  line_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        data_valid_out
);

  // Valid-only stream: a beat is consumed on every cycle data_valid_in=1.
  // There is no ready; the block never stalls and emits one beat per input beat.

  // data_in packing: [7:0]=row v-1, [15:8]=row v, [23:16]=row v+1.
  function automatic logic signed [12:0] row_w(input logic [7:0] a,
                                               input logic [7:0] b,
                                               input logic [7:0] c);
    return $signed(13'(a) + 13'({b, 1'b0}) + 13'(c));
  endfunction

  function automatic logic signed [12:0] col_w(input logic [23:0] c);
    return row_w(c[7:0], c[15:8], c[23:16]);
  endfunction

  function automatic logic signed [12:0] abs13(input logic signed [12:0] x);
    return (x < 0) ? -x : x;
  endfunction

  // S1: window and tags
  logic [23:0] c0, c1, c2;
  logic [10:0] h1, h_tag;
  logic [9:0]  v1, v_tag;
  logic [2:0]  k1, kernel_q, k_next;
  logic        val1;

  // S2: row/column partial sums
  logic signed [12:0] w0_2, w1_2, w2_2, top2, bot2, cen2, cross2;
  logic [10:0] h2;
  logic [9:0]  v2;
  logic [2:0]  k2;
  logic        val2;

  // S3: kernel result
  logic signed [12:0] res3, res_next, gx, gy;
  logic [10:0] h3;
  logic [9:0]  v3;
  logic        val3;

  // S4 combinational
  logic        border;
  logic [7:0]  clip_val;

  always_comb begin
    h_tag  = hcount_in - 11'd1;
    v_tag  = vcount_in;
    k_next = kernel_q;
    if (hcount_in == 11'd0) begin
      h_tag = 11'(HRES - 1);
      v_tag = (vcount_in == 10'd0) ? 10'(VRES - 1) : vcount_in - 10'd1;
      if (vcount_in == 10'd0) k_next = kernel_sel_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      c0 <= '0; c1 <= '0; c2 <= '0;
      h1 <= '0; v1 <= '0; k1 <= '0;
      kernel_q <= '0;
      val1 <= 1'b0;
    end else begin
      val1 <= data_valid_in;
      if (data_valid_in) begin
        c2 <= c1;
        c1 <= c0;
        c0 <= data_in;
        h1 <= h_tag;
        v1 <= v_tag;
        k1 <= k_next;
        kernel_q <= k_next;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      w0_2 <= '0; w1_2 <= '0; w2_2 <= '0;
      top2 <= '0; bot2 <= '0; cen2 <= '0; cross2 <= '0;
      h2 <= '0; v2 <= '0; k2 <= '0;
      val2 <= 1'b0;
    end else begin
      val2 <= val1;
      if (val1) begin
        w0_2   <= col_w(c0);
        w1_2   <= col_w(c1);
        w2_2   <= col_w(c2);
        top2   <= row_w(c2[7:0], c1[7:0], c0[7:0]);
        bot2   <= row_w(c2[23:16], c1[23:16], c0[23:16]);
        cen2   <= $signed(13'(c1[15:8]));
        cross2 <= $signed(13'(c1[7:0]) + 13'(c1[23:16]) + 13'(c0[15:8]) + 13'(c2[15:8]));
        h2 <= h1;
        v2 <= v1;
        k2 <= k1;
      end
    end
  end

  // Sobel takes left minus right (c2 - c0) and top minus bottom before abs.
  always_comb begin
    gx = w2_2 - w0_2;
    gy = top2 - bot2;
    case (k2)
      3'd1:    res_next = (w2_2 + (w1_2 <<< 1) + w0_2) >>> 4;
      3'd2:    res_next = (cen2 <<< 2) + cen2 - cross2;
      3'd3:    res_next = abs13(gx);
      3'd4:    res_next = abs13(gy);
      3'd5:    res_next = abs13(gx) + abs13(gy);
      default: res_next = cen2;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      res3 <= '0; h3 <= '0; v3 <= '0;
      val3 <= 1'b0;
    end else begin
      val3 <= val2;
      if (val2) begin
        res3 <= res_next;
        h3   <= h2;
        v3   <= v2;
      end
    end
  end

  always_comb begin
    border = (h3 == 11'd0) || (h3 == 11'(HRES - 1)) ||
             (v3 == 10'd0) || (v3 == 10'(VRES - 1));
    if (res3 < 0)              clip_val = 8'd0;
    else if (res3 > 13'sd255)  clip_val = 8'd255;
    else                       clip_val = res3[7:0];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      line_out       <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= val3;
      if (val3) begin
        line_out   <= border ? 8'd0 : clip_val;
        hcount_out <= h3;
        vcount_out <= v3;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_filter.sv
// Scoreboard bench for conv3x3_filter: image-based reference model, random
// idle gaps, kernel latching, tag wrap, border masking and reset behaviour.
module tb_conv3x3_filter;
  localparam int HRES = 320;
  localparam int VRES = 160;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [23:0] data_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        data_valid_in;
  logic [2:0]  kernel_sel_in;
  logic [7:0]  line_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        data_valid_out;

  conv3x3_filter #(.HRES(HRES), .VRES(VRES)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .data_valid_in(data_valid_in), .kernel_sel_in(kernel_sel_in),
    .line_out(line_out), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .data_valid_out(data_valid_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail = 0;
  int cur_k = 0;
  bit use_gaps = 1'b1;
  logic [28:0] exp_q[$];  // {line, hcount, vcount}

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Test images: 0 ramp, 1 flat, 2 impulse, 3 vertical step, 4 pseudo-random
  function automatic int pix(int pat, int x, int y);
    if (x < 0 || x > HRES - 1 || y < 0 || y > VRES - 1) return 0;
    case (pat)
      0:       return x % 256;
      1:       return 100;
      2:       return (x == 12 && y == 5) ? 255 : 0;
      3:       return (x >= 10) ? 255 : 0;
      default: return (x * 37 + y * 113 + ((x * y) >> 1)) % 256;
    endcase
  endfunction

  function automatic int model(int k, int pat, int ho, int vo);
    int p[3][3];
    int gx, gy, r, w;
    if (ho == 0 || ho == HRES - 1 || vo == 0 || vo == VRES - 1) return 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = pix(pat, ho + j - 1, vo + i - 1);
    gx = (p[0][0] + 2 * p[1][0] + p[2][0]) - (p[0][2] + 2 * p[1][2] + p[2][2]);
    gy = (p[0][0] + 2 * p[0][1] + p[0][2]) - (p[2][0] + 2 * p[2][1] + p[2][2]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    case (k)
      1: begin
        r = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            w = (i == 1 ? 2 : 1) * (j == 1 ? 2 : 1);
            r += w * p[i][j];
          end
        r = r / 16;
      end
      2:       r = 5 * p[1][1] - p[0][1] - p[2][1] - p[1][0] - p[1][2];
      3:       r = gx;
      4:       r = gy;
      5:       r = gx + gy;
      default: r = p[1][1];
    endcase
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic idle_inputs();
    data_valid_in = 1'b0;
    data_in       = 24'($urandom);
    hcount_in     = 11'($urandom_range(0, HRES - 1));
    vcount_in     = 10'($urandom_range(0, VRES - 1));
    kernel_sel_in = 3'($urandom_range(0, 7));
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat (and any gap).
  task automatic drive_pix(input int h, input int v, input logic [23:0] col,
                           input int sel, input int exp_line);
    int eh, ev;
    hcount_in     = 11'(h);
    vcount_in     = 10'(v);
    data_in       = col;
    kernel_sel_in = 3'(sel);
    data_valid_in = 1'b1;
    if (h != 0) begin
      eh = h - 1; ev = v;
    end else begin
      eh = HRES - 1; ev = (v == 0) ? VRES - 1 : v - 1;
    end
    exp_q.push_back({8'(exp_line), 11'(eh), 10'(ev)});
    @(posedge clk_in); #1;
    idle_inputs();
    if (use_gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk_in); #1; end
  endtask

  task automatic frame_start(input int sel);
    cur_k = sel;
    drive_pix(0, 0, 24'($urandom), sel, 0);
  endtask

  task automatic drive_rows(input int pat, input int sel, input int v_lo,
                            input int v_hi, input int h_hi);
    logic [23:0] col;
    for (int v = v_lo; v <= v_hi; v++)
      for (int h = 0; h <= h_hi; h++) begin
        col = {8'(pix(pat, h, v + 1)), 8'(pix(pat, h, v)), 8'(pix(pat, h, v - 1))};
        drive_pix(h, v, col, sel, (h == 0) ? 0 : model(cur_k, pat, h - 1, v));
      end
  endtask

  always @(negedge clk_in) begin
    logic [28:0] e;
    if (!rst_in && data_valid_out) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", 32'(data_valid_out), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("line_out", 32'(line_out), 32'(e[28:21]));
        check_eq("hcount_out", 32'(hcount_out), 32'(e[20:10]));
        check_eq("vcount_out", 32'(vcount_out), 32'(e[9:0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    rst_in = 1'b1;
    idle_inputs();
    // Reset with random inputs, valids included
    for (int i = 0; i < 2; i++) begin
      data_valid_in = 1'($urandom_range(0, 1));
      @(negedge clk_in);
      check_eq("rst_valid", 32'(data_valid_out), 32'd0);
      check_eq("rst_line", 32'(line_out), 32'd0);
      check_eq("rst_hcount", 32'(hcount_out), 32'd0);
      check_eq("rst_vcount", 32'(vcount_out), 32'd0);
      @(posedge clk_in); #1;
      idle_inputs();
    end
    rst_in = 1'b0;
    cur_k = 0;

    // Latency: identity on a cleared window gives 0 at (4,7)
    use_gaps = 1'b0;
    drive_pix(5, 7, 24'($urandom), 0, 0);
    repeat (3) begin
      @(negedge clk_in);
      check_eq("lat_early", 32'(data_valid_out), 32'd0);
    end
    @(negedge clk_in);
    check_eq("lat_hit", 32'(data_valid_out), 32'd1);
    @(posedge clk_in); #1;

    // Mid-frame reset drops in-flight beats and the kernel
    frame_start(1);
    drive_pix(1, 1, 24'($urandom), 1, 0);
    drive_pix(2, 1, 24'($urandom), 1, 0);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    exp_q.delete();
    cur_k = 0;
    repeat (6) begin
      @(negedge clk_in);
      check_eq("post_rst_valid", 32'(data_valid_out), 32'd0);
    end
    @(posedge clk_in); #1;
    use_gaps = 1'b1;

    // Identity on a ramp: full rows for the right border, bottom rows too
    frame_start(0);
    drive_rows(0, 0, 1, 3, HRES - 1);
    drive_rows(0, 0, VRES - 3, VRES - 1, 20);

    // Gaussian: flat field and impulse
    frame_start(1);
    drive_rows(1, 1, 1, 3, 30);
    drive_rows(2, 1, 3, 7, 20);

    // Sobel magnitude and sharpen on a vertical step
    frame_start(5);
    drive_rows(3, 5, 1, 3, 20);
    frame_start(2);
    drive_rows(3, 2, 1, 3, 20);

    // Every select value on a pseudo-random image
    for (int k = 0; k < 8; k++) begin
      frame_start(k);
      drive_rows(4, k, 1, 3, 30);
    end

    // Mid-frame select changes are ignored until the next (0,0) beat
    frame_start(1);
    drive_rows(4, 4, 1, 3, 30);
    frame_start(4);
    drive_rows(4, 1, 1, 3, 30);

    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(posedge clk_in); #1;
      waited++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
